// File: rtl/diag_pkg.sv
// Shared types for the front-end diagnostic sequencer.
//   tDiagFunction : EBUS diag function codes.
//                   Vector bit 6 carries ds[0] and bit 0 carries ds[6].
//   RESET_SEQ_LEN : number of entries in the master-reset table.
//   tFeSeqState   : sequencer FSM states.
// Config macro: KL_RESET_START_CLK_EN adds START_CLOCK as a 12th table entry.
package diag_pkg;

  typedef enum logic [6:0] {
    STOP_CLOCK           = 7'o000,
    START_CLOCK          = 7'o001,
    CLR_RESET            = 7'o006,
    SET_RESET            = 7'o007,
    CLR_BURST_CTR_RH     = 7'o042,
    CLR_BURST_CTR_LH     = 7'o043,
    CLR_CLK_SRC_RATE     = 7'o044,
    RESET_PAR_REGS       = 7'o046,
    CLR_CRAM_DIAG_ADR_RH = 7'o051,
    CLR_CRAM_DIAG_ADR_LH = 7'o052,
    ENABLE_KL            = 7'o067,
    EBUS_LOAD            = 7'o076
  } tDiagFunction;

`ifdef KL_RESET_START_CLK_EN
  localparam int unsigned RESET_SEQ_LEN = 12;
`else
  localparam int unsigned RESET_SEQ_LEN = 11;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    STROBE,
    GAP
  } tFeSeqState;

endpackage

// File: rtl/fe_reset_seq_rom.sv
// Master-reset function table (combinational lookup).
//   index : table position, 0 = first function issued.
//   func  : diag function at that position.
//           Positions past the end of the table return STOP_CLOCK.
// Config macro: KL_RESET_START_CLK_EN appends START_CLOCK after EBUS_LOAD.
module fe_reset_seq_rom
  import diag_pkg::*;
(
  input  logic [3:0]   index,
  output tDiagFunction func
);

  always_comb begin
    func = STOP_CLOCK;
    case (index)
      4'd0:    func = SET_RESET;
      4'd1:    func = CLR_RESET;
      4'd2:    func = STOP_CLOCK;
      4'd3:    func = CLR_CLK_SRC_RATE;
      4'd4:    func = RESET_PAR_REGS;
      4'd5:    func = CLR_BURST_CTR_RH;
      4'd6:    func = CLR_BURST_CTR_LH;
      4'd7:    func = CLR_CRAM_DIAG_ADR_LH;
      4'd8:    func = CLR_CRAM_DIAG_ADR_RH;
      4'd9:    func = ENABLE_KL;
      4'd10:   func = EBUS_LOAD;
`ifdef KL_RESET_START_CLK_EN
      4'd11:   func = START_CLOCK;
`endif
      default: func = STOP_CLOCK;
    endcase
  end

endmodule

// File: rtl/fe_diag_sequencer.sv
// Front-end diagnostic-function sequencer; sole driver of EBUS ds/diagStrobe.
// It issues either a single requested diag function or the full master-reset table.
//   clk            : EBOX master clock.
//   CROBAR         : asynchronous active-high reset.
//   mhz16Tick      : one-clk pacing pulse; all strobe/gap timing counts these.
//   resetReq       : request the master-reset table.
//                    Latched while busy; several requests collapse into one.
//   funcReq        : request one diag function; hold until funcAck.
//   funcCode       : code of the requested diag function.
//   funcAck        : one-clk pulse when the single function's gap ends.
//   ebusDs         : EBUS.ds (bit 6 = ds[0]).
//   ebusDiagStrobe : EBUS.diagStrobe.
//   busy           : high when the FSM is not idle or a reset request is pending.
//   seqDone        : one-clk pulse when the last table entry's gap ends.
// Parameters:
//   STROBE_TICKS   : strobe width in ticks (1..15).
//   GAP_TICKS      : idle gap after each function in ticks (1..15).
// Config macro: KL_RESET_START_CLK_EN (table length, see diag_pkg).
module fe_diag_sequencer
  import diag_pkg::*;
#(
  parameter int unsigned STROBE_TICKS = 9,
  parameter int unsigned GAP_TICKS    = 4
)(
  input  logic       clk,
  input  logic       CROBAR,
  input  logic       mhz16Tick,
  input  logic       resetReq,
  input  logic       funcReq,
  input  logic [6:0] funcCode,
  output logic       funcAck,
  output logic [6:0] ebusDs,
  output logic       ebusDiagStrobe,
  output logic       busy,
  output logic       seqDone
);

  localparam logic [3:0] LAST_INDEX = 4'(RESET_SEQ_LEN - 1);
  localparam logic [3:0] STROBE_END = 4'(STROBE_TICKS);
  localparam logic [3:0] GAP_END    = 4'(GAP_TICKS - 1);

  tFeSeqState   state, state_nx;
  logic [6:0]   code, code_nx;
  logic [3:0]   index, index_nx;
  logic [3:0]   cnt, cnt_nx;
  logic         pending, pending_nx;
  logic         table_mode, table_mode_nx;
  logic [6:0]   ds_nx;
  logic         strobe_nx, ack_nx, done_nx;
  tDiagFunction rom_func;

  fe_reset_seq_rom u_rom (
    .index (index),
    .func  (rom_func)
  );

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state          <= IDLE;
      code           <= '0;
      index          <= '0;
      cnt            <= '0;
      pending        <= 1'b0;
      table_mode     <= 1'b0;
      ebusDs         <= '0;
      ebusDiagStrobe <= 1'b0;
      funcAck        <= 1'b0;
      seqDone        <= 1'b0;
    end else begin
      state          <= state_nx;
      code           <= code_nx;
      index          <= index_nx;
      cnt            <= cnt_nx;
      pending        <= pending_nx;
      table_mode     <= table_mode_nx;
      ebusDs         <= ds_nx;
      ebusDiagStrobe <= strobe_nx;
      funcAck        <= ack_nx;
      seqDone        <= done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    code_nx       = code;
    index_nx      = index;
    cnt_nx        = cnt;
    // A request seen in any non-idle state is held until the FSM returns to IDLE.
    pending_nx    = pending | resetReq;
    table_mode_nx = table_mode;
    ds_nx         = ebusDs;
    strobe_nx     = ebusDiagStrobe;
    ack_nx        = 1'b0;
    done_nx       = 1'b0;

    case (state)
      IDLE: begin
        if (pending || resetReq) begin
          pending_nx    = 1'b0;
          table_mode_nx = 1'b1;
          index_nx      = '0;
          state_nx      = ARM;
        end else if (funcReq) begin
          table_mode_nx = 1'b0;
          code_nx       = funcCode;
          state_nx      = ARM;
        end
      end

      ARM: begin
        if (mhz16Tick) begin
          ds_nx     = table_mode ? 7'(rom_func) : code;
          strobe_nx = 1'b1;
          cnt_nx    = 4'd1;
          state_nx  = STROBE;
        end
      end

      STROBE: begin
        if (mhz16Tick) begin
          if (cnt == STROBE_END) begin
            ds_nx     = '0;
            strobe_nx = 1'b0;
            cnt_nx    = '0;
            state_nx  = GAP;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end

      GAP: begin
        if (mhz16Tick) begin
          if (cnt == GAP_END) begin
            cnt_nx = '0;
            if (!table_mode) begin
              ack_nx   = 1'b1;
              state_nx = IDLE;
            end else if (index == LAST_INDEX) begin
              done_nx  = 1'b1;
              state_nx = IDLE;
            end else begin
              index_nx = index + 4'd1;
              state_nx = ARM;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || pending;

endmodule

// File: tb/tb_fe_diag_sequencer.sv
module tb_fe_diag_sequencer;

`ifdef KL_RESET_START_CLK_EN
  localparam int SEQ_LEN = 12;
`else
  localparam int SEQ_LEN = 11;
`endif
  localparam int CLK_PER_TICK = 4;
  localparam int HIGH_CLK = 9 * CLK_PER_TICK;        // strobe width
  localparam int ACK_CLK  = 4 * CLK_PER_TICK;        // strobe fall to gap end
  localparam int GAP_CLK  = 5 * CLK_PER_TICK;        // fall to next rise (gap + ARM wait)
  localparam int FUNC_CLK = HIGH_CLK + GAP_CLK;

  logic clk = 1'b0;
  logic CROBAR, mhz16Tick, resetReq, funcReq;
  logic [6:0] funcCode;
  logic funcAck, ebusDiagStrobe, busy, seqDone;
  logic [6:0] ebusDs;

  logic tick_f, funcReq_f, funcAck_f, strobe_f, busy_f, seqDone_f;
  logic [6:0] funcCode_f, ds_f;

  int total = 0;
  int bad = 0;

  logic [6:0] exp_tab [12] = '{7'o007, 7'o006, 7'o000, 7'o044, 7'o046, 7'o042,
                               7'o043, 7'o052, 7'o051, 7'o067, 7'o076, 7'o001};

  fe_diag_sequencer u_dut (
    .clk(clk), .CROBAR(CROBAR), .mhz16Tick(mhz16Tick), .resetReq(resetReq),
    .funcReq(funcReq), .funcCode(funcCode), .funcAck(funcAck), .ebusDs(ebusDs),
    .ebusDiagStrobe(ebusDiagStrobe), .busy(busy), .seqDone(seqDone)
  );

  fe_diag_sequencer #(.STROBE_TICKS(1), .GAP_TICKS(1)) u_fast (
    .clk(clk), .CROBAR(CROBAR), .mhz16Tick(tick_f), .resetReq(1'b0),
    .funcReq(funcReq_f), .funcCode(funcCode_f), .funcAck(funcAck_f), .ebusDs(ds_f),
    .ebusDiagStrobe(strobe_f), .busy(busy_f), .seqDone(seqDone_f)
  );

  initial forever #5 clk = ~clk;

  // Tick every 4th clk, changed on the falling edge.
  initial begin
    int unsigned phase;
    phase = 0;
    mhz16Tick = 1'b0;
    forever begin
      @(negedge clk);
      mhz16Tick = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  // Event recorder for the main instance.
  int cyc = 0;
  int rise_t[$], fall_t[$], ack_t[$], done_t[$];
  logic [6:0] rise_ds[$];
  int ds_change_bad = 0;
  int ds_idle_bad = 0;
  logic prev_strobe = 1'b0;
  logic [6:0] prev_ds = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (ebusDiagStrobe && !prev_strobe) begin
      rise_t.push_back(cyc);
      rise_ds.push_back(ebusDs);
    end
    if (!ebusDiagStrobe && prev_strobe) fall_t.push_back(cyc);
    if (ebusDiagStrobe && prev_strobe && ebusDs !== prev_ds) ds_change_bad++;
    if (!ebusDiagStrobe && ebusDs !== 7'o000) ds_idle_bad++;
    if (funcAck) ack_t.push_back(cyc);
    if (seqDone) done_t.push_back(cyc);
    prev_strobe = ebusDiagStrobe;
    prev_ds = ebusDs;
  end

  a_ds_stable: assert property (@(posedge clk) disable iff (CROBAR)
      (ebusDiagStrobe && $past(ebusDiagStrobe)) |-> (ebusDs == $past(ebusDs)))
    else $error("FAIL ds_stable: ds changed while strobe high");
  a_ds_stable_f: assert property (@(posedge clk) disable iff (CROBAR)
      (strobe_f && $past(strobe_f)) |-> (ds_f == $past(ds_f)))
    else $error("FAIL ds_stable_fast: ds changed while strobe high");

  task automatic clear_log();
    rise_t.delete(); fall_t.delete(); ack_t.delete(); done_t.delete(); rise_ds.delete();
  endtask

  task automatic pulse_reset_req();
    @(negedge clk); resetReq = 1'b1;
    @(negedge clk); resetReq = 1'b0;
  endtask

  task automatic test_reset();
    CROBAR = 1'b1; resetReq = 1'b0; funcReq = 1'b0; funcCode = '0;
    tick_f = 1'b1; funcReq_f = 1'b0; funcCode_f = '0;
    repeat (3) @(negedge clk);
    total++; if (ebusDiagStrobe !== 1'b0) begin bad++; $display("FAIL rst_strobe: got %b want 0", ebusDiagStrobe); end
    total++; if (ebusDs !== 7'o000) begin bad++; $display("FAIL rst_ds: got %o want 0", ebusDs); end
    total++; if ({busy, funcAck, seqDone} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy, funcAck, seqDone}); end
    total++; if ({busy_f, strobe_f, ds_f} !== 9'd0) begin bad++; $display("FAIL rst_fast: got %b want 0", {busy_f, strobe_f, ds_f}); end
    CROBAR = 1'b0;
    repeat (20) @(negedge clk);
    total++; if ({busy, ebusDiagStrobe, busy_f, strobe_f} !== 4'b0000) begin bad++; $display("FAIL idle_after_rst: got %b want 0000", {busy, ebusDiagStrobe, busy_f, strobe_f}); end
  endtask

  task automatic test_single_func();
    int n;
    bit busy_seen;
    clear_log();
    busy_seen = 1'b0;
    @(negedge clk); funcCode = 7'o067; funcReq = 1'b1;
    n = 0;
    while (ack_t.size() == 0 && n < 400) begin
      @(posedge clk); #2; n++;
      if (busy) busy_seen = 1'b1;
    end
    funcReq = 1'b0;
    total++; if (ack_t.size() != 1) begin bad++; $display("FAIL t1_ack: got %0d acks want 1", ack_t.size()); end
    repeat (5) @(posedge clk); #2;
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL t1_busy_run: got %b want 1", busy_seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end: got %b want 0", busy); end
    total++; if (rise_t.size() != 1 || fall_t.size() != 1) begin bad++; $display("FAIL t1_strobes: got %0d/%0d want 1/1", rise_t.size(), fall_t.size()); end
    else begin
      total++; if (rise_ds[0] !== 7'o067) begin bad++; $display("FAIL t1_ds: got %o want 067", rise_ds[0]); end
      total++; if (fall_t[0] - rise_t[0] != HIGH_CLK) begin bad++; $display("FAIL t1_high: got %0d want %0d", fall_t[0] - rise_t[0], HIGH_CLK); end
      if (ack_t.size() == 1) begin
        total++; if (ack_t[0] - fall_t[0] != ACK_CLK) begin bad++; $display("FAIL t1_gap: got %0d want %0d", ack_t[0] - fall_t[0], ACK_CLK); end
      end
    end
    total++; if (done_t.size() != 0) begin bad++; $display("FAIL t1_seqdone: got %0d want 0", done_t.size()); end
  endtask

  task automatic test_reset_table();
    int n;
    clear_log();
    pulse_reset_req();
    n = 0;
    while (done_t.size() == 0 && n < 3000) begin @(posedge clk); #2; n++; end
    repeat (30) @(posedge clk); #2;
    total++; if (done_t.size() != 1) begin bad++; $display("FAIL t2_done: got %0d want 1", done_t.size()); end
    total++; if (rise_t.size() != SEQ_LEN) begin bad++; $display("FAIL t2_count: got %0d want %0d", rise_t.size(), SEQ_LEN); end
    total++; if (ack_t.size() != 0) begin bad++; $display("FAIL t2_ack: got %0d want 0", ack_t.size()); end
    for (int i = 0; i < SEQ_LEN && i < rise_t.size(); i++) begin
      total++; if (rise_ds[i] !== exp_tab[i]) begin bad++; $display("FAIL t2_ds[%0d]: got %o want %o", i, rise_ds[i], exp_tab[i]); end
      if (i < fall_t.size()) begin
        total++; if (fall_t[i] - rise_t[i] != HIGH_CLK) begin bad++; $display("FAIL t2_high[%0d]: got %0d want %0d", i, fall_t[i] - rise_t[i], HIGH_CLK); end
      end
      if (i > 0 && i <= fall_t.size()) begin
        total++; if (rise_t[i] - fall_t[i-1] != GAP_CLK) begin bad++; $display("FAIL t2_gap[%0d]: got %0d want %0d", i, rise_t[i] - fall_t[i-1], GAP_CLK); end
      end
    end
    if (done_t.size() == 1 && fall_t.size() == SEQ_LEN && rise_t.size() == SEQ_LEN) begin
      total++; if (done_t[0] - fall_t[SEQ_LEN-1] != ACK_CLK) begin bad++; $display("FAIL t2_last_gap: got %0d want %0d", done_t[0] - fall_t[SEQ_LEN-1], ACK_CLK); end
      total++; if (done_t[0] - rise_t[0] != (SEQ_LEN-1)*FUNC_CLK + HIGH_CLK + ACK_CLK) begin bad++; $display("FAIL t2_span: got %0d want %0d", done_t[0] - rise_t[0], (SEQ_LEN-1)*FUNC_CLK + HIGH_CLK + ACK_CLK); end
    end
    total++; if (ds_idle_bad != 0) begin bad++; $display("FAIL t2_ds_idle: got %0d want 0", ds_idle_bad); end
  endtask

  task automatic test_reset_beats_func();
    int n;
    clear_log();
    @(negedge clk); resetReq = 1'b1; funcReq = 1'b1; funcCode = 7'o001;
    @(negedge clk); resetReq = 1'b0;
    n = 0;
    while (ack_t.size() == 0 && n < 3000) begin @(posedge clk); #2; n++; end
    funcReq = 1'b0;
    repeat (30) @(posedge clk); #2;
    total++; if (rise_t.size() != SEQ_LEN + 1) begin bad++; $display("FAIL t3_count: got %0d want %0d", rise_t.size(), SEQ_LEN + 1); end
    else begin
      total++; if (rise_ds[0] !== 7'o007) begin bad++; $display("FAIL t3_first: got %o want 007", rise_ds[0]); end
      total++; if (rise_ds[SEQ_LEN] !== 7'o001) begin bad++; $display("FAIL t3_func_ds: got %o want 001", rise_ds[SEQ_LEN]); end
    end
    total++; if (ack_t.size() != 1 || done_t.size() != 1) begin bad++; $display("FAIL t3_pulses: got ack=%0d done=%0d want 1/1", ack_t.size(), done_t.size()); end
    else begin
      total++; if (!(done_t[0] < ack_t[0])) begin bad++; $display("FAIL t3_order: got done@%0d ack@%0d want done first", done_t[0], ack_t[0]); end
    end
  endtask

  task automatic test_collapse_reqs();
    int n;
    clear_log();
    pulse_reset_req();
    n = 0;
    while (rise_t.size() < 4 && n < 1000) begin @(posedge clk); #2; n++; end
    total++; if (rise_t.size() != 4) begin bad++; $display("FAIL t4_reach_e3: got %0d rises want 4", rise_t.size()); end
    pulse_reset_req();
    repeat (5) @(negedge clk);
    pulse_reset_req();
    n = 0;
    while (done_t.size() < 2 && n < 4000) begin @(posedge clk); #2; n++; end
    repeat (200) @(posedge clk); #2;
    total++; if (done_t.size() != 2) begin bad++; $display("FAIL t4_done: got %0d want 2", done_t.size()); end
    total++; if (rise_t.size() != 2 * SEQ_LEN) begin bad++; $display("FAIL t4_count: got %0d want %0d", rise_t.size(), 2 * SEQ_LEN); end
    else begin
      total++; if (rise_ds[SEQ_LEN] !== 7'o007) begin bad++; $display("FAIL t4_restart: got %o want 007", rise_ds[SEQ_LEN]); end
      total++; if (rise_ds[2*SEQ_LEN-1] !== exp_tab[SEQ_LEN-1]) begin bad++; $display("FAIL t4_last: got %o want %o", rise_ds[2*SEQ_LEN-1], exp_tab[SEQ_LEN-1]); end
    end
    total++; if (busy !== 1'b0 || ack_t.size() != 0) begin bad++; $display("FAIL t4_end: got busy=%b ack=%0d want 0/0", busy, ack_t.size()); end
  endtask

  task automatic test_crobar_mid_strobe();
    int n;
    clear_log();
    pulse_reset_req();
    n = 0;
    while (rise_t.size() < 6 && n < 1000) begin @(posedge clk); #2; n++; end
    repeat (8) @(negedge clk);
    total++; if (ebusDiagStrobe !== 1'b1 || ebusDs !== exp_tab[5]) begin bad++; $display("FAIL t5_pre: got strobe=%b ds=%o want 1/%o", ebusDiagStrobe, ebusDs, exp_tab[5]); end
    CROBAR = 1'b1;
    #1;
    total++; if (ebusDiagStrobe !== 1'b0) begin bad++; $display("FAIL t5_strobe: got %b want 0", ebusDiagStrobe); end
    total++; if (ebusDs !== 7'o000) begin bad++; $display("FAIL t5_ds: got %o want 0", ebusDs); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy: got %b want 0", busy); end
    @(negedge clk); CROBAR = 1'b0;
    repeat (300) @(posedge clk); #2;
    total++; if (rise_t.size() != 6 || done_t.size() != 0) begin bad++; $display("FAIL t5_no_resume: got rises=%0d done=%0d want 6/0", rise_t.size(), done_t.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_idle: got %b want 0", busy); end
  endtask

  task automatic test_fast_ticks();
    int rise, fall, ack, ds_bad;
    logic prev, rise_seen;
    logic [6:0] pds, rds;
    rise = -1; fall = -1; ack = -1; ds_bad = 0;
    prev = 1'b0; pds = '0; rds = '0; rise_seen = 1'b0;
    @(negedge clk); funcCode_f = 7'o046; funcReq_f = 1'b1;
    for (int i = 0; i < 40 && ack < 0; i++) begin
      @(posedge clk); #1;
      if (strobe_f && !prev) begin rise = i; rds = ds_f; rise_seen = 1'b1; end
      if (!strobe_f && prev && fall < 0) fall = i;
      if (strobe_f && prev && ds_f !== pds) ds_bad++;
      if (funcAck_f) begin ack = i; funcReq_f = 1'b0; end
      prev = strobe_f; pds = ds_f;
    end
    funcReq_f = 1'b0;
    total++; if (ack < 0 || !rise_seen || fall < 0) begin bad++; $display("FAIL t6_events: got rise=%0d fall=%0d ack=%0d want all seen", rise, fall, ack); end
    else begin
      total++; if (fall - rise != 1) begin bad++; $display("FAIL t6_high: got %0d want 1", fall - rise); end
      total++; if (ack - fall != 1) begin bad++; $display("FAIL t6_ack: got %0d want 1", ack - fall); end
      total++; if (rds !== 7'o046) begin bad++; $display("FAIL t6_ds: got %o want 046", rds); end
    end
    total++; if (ds_bad != 0) begin bad++; $display("FAIL t6_ds_stable: got %0d want 0", ds_bad); end
    repeat (3) @(posedge clk); #1;
    total++; if (busy_f !== 1'b0 || strobe_f !== 1'b0) begin bad++; $display("FAIL t6_end: got busy=%b strobe=%b want 0/0", busy_f, strobe_f); end
  endtask

  initial begin
    test_reset();
    test_single_func();
    test_reset_table();
    test_reset_beats_func();
    test_collapse_reqs();
    test_crobar_mid_strobe();
    test_fast_ticks();
    total++; if (ds_change_bad != 0) begin bad++; $display("FAIL ds_stable_main: got %0d want 0", ds_change_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
